// File: rtl/code_conv_arbiter.sv
// Two-requester round-robin arbiter in front of one shared binary/Gray
// converter, with a single registered result stage under valid/ready flow control.
module code_conv_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic         req0_mode,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  input  logic         req1_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_id,
  output logic         out_mode
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   data_q, data_d;
  logic           id_q, id_d;
  logic           mode_q, mode_d;
  logic           last_grant_q, last_grant_d;

  logic           can_accept;
  logic           grant_vld;
  logic           grant_id;
  logic           accept;
  logic [W-1:0]   sel_data;
  logic           sel_mode;

  // Mode 0: binary->Gray. Mode 1: Gray->binary via a running XOR from the MSB down.
  function automatic logic [W-1:0] conv(input logic [W-1:0] v, input logic m);
    logic [W-1:0] r;
    r = '0;
    if (!m) begin
      r = v ^ (v >> 1);
    end else begin
      r[W-1] = v[W-1];
      for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_mode  = mode_q;

  // Grant selection: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    can_accept = ~out_valid | out_ready;
    grant_vld  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = ~rst & can_accept & grant_vld & ~grant_id;
    req1_ready = ~rst & can_accept & grant_vld &  grant_id;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    sel_data   = grant_id ? req1_data : req0_data;
    sel_mode   = grant_id ? req1_mode : req0_mode;
  end

  // Next state of the result register: reload on accept, empty on drain-only, else hold.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    mode_d       = mode_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = FULL;
      data_d       = conv(sel_data, sel_mode);
      id_d         = grant_id;
      mode_d       = sel_mode;
      last_grant_d = grant_id;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Registers; reset clears the result and biases the first contention toward requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      mode_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      mode_q       <= mode_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Self-checking bench for code_conv_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level reference.
module tb_code_conv_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_mode = 1'b0, req1_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_id, out_mode;

  int checks = 0;
  int failures = 0;

  code_conv_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_mode(req1_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  // Reference conversion: Gray is b^(b>>1); the inverse is found by searching
  // for the binary word whose Gray code matches.
  function automatic logic [W-1:0] ref_conv(input logic [W-1:0] v, input logic m);
    logic [W-1:0] b;
    if (!m) return v ^ (v >> 1);
    for (int k = 0; k < (1 << W); k++) begin
      b = k[W-1:0];
      if ((b ^ (b >> 1)) == v) return b;
    end
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; out_ready = 1;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; out_ready = 1;
    req0_data = 4'd0; req0_mode = 0; req1_data = 4'd1; req1_mode = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d: out_valid=%b r0=%b r1=%b, want 0 0 0", c, out_valid, req0_ready, req1_ready);
      end
    end
    checks++;
    if (out_data !== 4'd0 || out_id !== 1'b0 || out_mode !== 1'b0) begin
      failures++;
      $display("FAIL reset_fields: data=%h id=%b mode=%b, want 0 0 0", out_data, out_id, out_mode);
    end
    rst = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_data = 4'd5; req0_mode = 0; out_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: r0=%b want 1", req0_ready);
    end
    tick();
    req0_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd7 || out_id !== 1'b0 || out_mode !== 1'b0) begin
      failures++;
      $display("FAIL single_out: v=%b data=%h id=%b mode=%b, want 1 7 0 0", out_valid, out_data, out_id, out_mode);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_d;
    logic         exp_i;
    apply_reset();
    req0_valid = 1; req0_data = 4'd6; req0_mode = 0;
    req1_valid = 1; req1_data = 4'b1000; req1_mode = 1;
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      exp_i = c[0];
      exp_d = exp_i ? 4'd15 : 4'd5;
      #1;
      checks++;
      if (req0_ready !== ~exp_i || req1_ready !== exp_i) begin
        failures++;
        $display("FAIL contention_ready c=%0d: r0=%b r1=%b, want %b %b", c, req0_ready, req1_ready, ~exp_i, exp_i);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== exp_i || out_data !== exp_d || out_mode !== exp_i) begin
        failures++;
        $display("FAIL contention_out c=%0d: v=%b id=%b data=%h mode=%b, want 1 %b %h %b",
                 c, out_valid, out_id, out_data, out_mode, exp_i, exp_d, exp_i);
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    // Last contention winner is requester 1, so a lone req0 is served first.
    req0_valid = 1; req0_data = 4'd3; req0_mode = 0; out_ready = 1;
    tick();
    req0_data = 4'd9; req1_valid = 1; req1_data = 4'd10; req1_mode = 0;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd2 || out_id !== 1'b0 || out_mode !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold c=%0d: v=%b data=%h id=%b r0=%b r1=%b, want 1 2 0 0 0",
                 c, out_valid, out_data, out_id, req0_ready, req1_ready);
      end
      tick();
    end
    out_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_id !== 1'b1 || out_data !== 4'd15) begin
      failures++;
      $display("FAIL backpressure_next: v=%b id=%b data=%h, want 1 1 f", out_valid, out_id, out_data);
    end
    tick();
  endtask

  task automatic test_round_trip();
    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    logic [W-1:0] g;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1; req0_data = i[W-1:0]; req0_mode = 0;
      tick();
      req0_valid = 0;
      g = out_data;
      checks++;
      if (out_valid !== 1'b1 || out_data !== gtab[i][W-1:0] || out_id !== 1'b0) begin
        failures++;
        $display("FAIL round_trip_gray i=%0d: v=%b data=%h id=%b, want 1 %h 0", i, out_valid, out_data, out_id, gtab[i][W-1:0]);
      end
      req1_valid = 1; req1_data = g; req1_mode = 1;
      tick();
      req1_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== i[W-1:0] || out_id !== 1'b1 || out_mode !== 1'b1) begin
        failures++;
        $display("FAIL round_trip_bin i=%0d: v=%b data=%h id=%b mode=%b, want 1 %h 1 1", i, out_valid, out_data, out_id, out_mode, i[W-1:0]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1; req1_data = 4'd4; req1_mode = 0; out_ready = 1;
    tick();
    req1_valid = 0; out_ready = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: v=%b id=%b, want 1 1", out_valid, out_id);
    end
    rst = 1; req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ready: r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
    end
    tick();
    rst = 0; req0_valid = 0; req1_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_id !== 1'b0 || out_mode !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: v=%b data=%h id=%b mode=%b, want 0 0 0 0", out_valid, out_data, out_id, out_mode);
    end
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_last_grant: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_discard c=%0d: out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  // Random traffic against a transaction-level model: pending requests, an
  // occupancy flag for the result slot, and "who was served last" for fairness.
  task automatic test_random();
    logic         m_full, m_id, m_mode, m_last;
    logic [W-1:0] m_data;
    logic         any, win, can, e_r0, e_r1;
    apply_reset();
    m_full = 0; m_last = 1; m_data = '0; m_id = 0; m_mode = 0;
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid || req0_ready) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_data  = W'($urandom);
        req0_mode  = $urandom_range(0, 1) == 1;
      end
      if (!req1_valid || req1_ready) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_data  = W'($urandom);
        req1_mode  = $urandom_range(0, 1) == 1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      can  = !m_full || out_ready;
      any  = req0_valid || req1_valid;
      win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = can && any && !win;
      e_r1 = can && any && win;
      checks++;
      if (req0_ready !== e_r0 || req1_ready !== e_r1 || out_valid !== m_full ||
          (m_full && (out_data !== m_data || out_id !== m_id || out_mode !== m_mode))) begin
        failures++;
        $display("FAIL random c=%0d: r0=%b r1=%b v=%b d=%h id=%b m=%b, want %b %b %b %h %b %b",
                 c, req0_ready, req1_ready, out_valid, out_data, out_id, out_mode,
                 e_r0, e_r1, m_full, m_data, m_id, m_mode);
      end
      if (e_r0 || e_r1) begin
        m_full = 1; m_id = win; m_last = win;
        m_mode = win ? req1_mode : req0_mode;
        m_data = ref_conv(win ? req1_data : req0_data, m_mode);
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_round_trip();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_conv_arbiter.md
Name: code_conv_arbiter

Overview:
- Round-robin arbiter that shares one binary/Gray code conversion datapath between two requesters.
- Each requester issues valid/ready transactions carrying a data word and a direction bit:
  - 0 = binary-to-Gray.
  - 1 = Gray-to-binary.
- Results leave through a single registered output stage with valid/ready backpressure, tagged with the originating requester ID.
- Sits between client blocks and the converter logic so that only one converter instance is needed.

Parameters:
- W, 4, data word width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a transaction.
- req0_ready  output  1  requester 0 transaction accepted this cycle.
- req0_data  input  W  requester 0 operand.
- req0_mode  input  1  requester 0 direction (0 bin->gray, 1 gray->bin).
- req1_valid  input  1  requester 1 has a transaction.
- req1_ready  output  1  requester 1 transaction accepted this cycle.
- req1_data  input  W  requester 1 operand.
- req1_mode  input  1  requester 1 direction.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  converted word.
- out_id  output  1  requester that produced out_data.
- out_mode  output  1  direction used for out_data.

Behaviour:
- Reset (synchronous, rst=1 at rising edge) clears all state:
  - out_valid=0, out_data=0, out_id=0, out_mode=0, last_grant=1 (so requester 0 wins the first contention).
  - reset has priority over every other event, including a transfer in progress.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = ~out_valid | out_ready. Combinational.
- Grant (combinational):
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant ~last_grant.
  - Neither set: no grant.
- reqN_ready = can_accept & (grant == N). At most one ready high per cycle.
  - Ready may depend combinationally on valid.
  - Ready is 0 while rst=1.
- Accept event (reqN_valid & reqN_ready at clock edge):
  - out_data <= conv(reqN_data, reqN_mode).
  - out_id <= N; out_mode <= reqN_mode.
  - out_valid <= 1; last_grant <= N.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: one transaction per cycle while out_ready=1.
- Drain only (out_valid & out_ready, no accept): out_valid <= 0. Data fields hold their last values.
- Simultaneous drain and accept: the register reloads with the new result; out_valid stays 1 with no bubble.
- Backpressure (out_valid=1, out_ready=0):
  - out_data, out_id and out_mode hold stable.
  - Both ready outputs are 0.
  - last_grant is unchanged.
- Fairness: with both requesters continuously valid and out_ready=1, grants strictly alternate 0,1,0,1...
- A requester must hold data/mode stable while valid and not ready. The block does not check this.
- Conversion, W bits, no width growth:
  - bin->gray: g = b ^ (b >> 1).
  - gray->bin: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0.
- Mode is per transaction. Mixed modes from the two requesters are allowed in back-to-back cycles.
- Wrap-around: for W=4, input 4'hF in bin->gray gives 4'h8; input 4'h8 in gray->bin gives 4'hF. No overflow condition exists.

Test Plan:
- Reset then idle: assert rst for 2 cycles with both valids high.
  - Required: out_valid=0, req0_ready=req1_ready=0 during reset.
  - Required: first grant after release goes to requester 0.
- Single transfer: req0_valid=1, req0_data=4'd5, mode=0, out_ready=1.
  - Required: req0_ready=1 that cycle.
  - Required next cycle: out_valid=1, out_data=4'd7, out_id=0, out_mode=0.
- Contention with mixed modes, both valid for 4 cycles:
  - Inputs: req0 = 4'd6 mode 0; req1 = 4'b1000 mode 1.
  - Required outputs in order: id 0 data 4'd5, id 1 data 4'd15, id 0 data 4'd5, id 1 data 4'd15, with no idle cycles.
- Backpressure: hold out_ready=0 for 3 cycles while a result is FULL and both requesters are valid.
  - Required: output fields constant; both ready outputs 0.
  - Required: when out_ready rises, the held result drains and the next result (other requester) appears the following cycle.
- Round trip: req0 sends 0..15 with mode 0; requester 1 then feeds each out_data back with mode 1.
  - Required: recovered values equal 0..15.
  - Required Gray outputs: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0.
  - Required next cycle: out_valid=0, out_data=0, last_grant=1.
  - Required: the pending result is discarded and not emitted after reset.
